// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word-only data_bus traffic,
// using read-modify-write for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned/illegal sizes.
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        bus_r_en,
    output logic [31:0] bus_r_addr,
    input  logic [31:0] bus_r_data,
    output logic        bus_w_en,
    output logic [31:0] bus_w_addr,
    output logic [31:0] bus_w_data
);

    localparam int unsigned LAT_W = 4;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic              r_en_q;
    logic              w_en_q;

    logic [1:0]        size_c;
    logic [1:0]        lane_c;
    logic              fault_c;
    logic [31:0]       word_addr_c;
    logic [4:0]        shamt_c;
    logic [31:0]       shifted_c;
    logic [31:0]       load_c;
    logic [31:0]       mask_c;
    logic [31:0]       merge_c;

    // Request decode: normalised size and lane (byte offset of the accessed field)
    always_comb begin
        size_c = (req_size == 2'b11) ? SZ_WORD : req_size;
        case (size_c)
            SZ_BYTE: lane_c = req_addr[1:0];
            SZ_HALF: lane_c = {req_addr[1], 1'b0};
            default: lane_c = 2'b00;
        endcase
        word_addr_c = {req_addr[31:2], 2'b00};
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q;

    assign fault_c   = (req_size == 2'b11)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign rsp_fault = fault_q;
`else
    assign fault_c   = 1'b0;
    assign rsp_fault = 1'b0;
`endif

    // Load extraction and sub-word store merge, both from the sampled bus word
    always_comb begin
        shamt_c   = {lane_q, 3'b000};
        shifted_c = bus_r_data >> shamt_c;
        case (size_q)
            SZ_BYTE: load_c = {{24{~uns_q & shifted_c[7]}}, shifted_c[7:0]};
            SZ_HALF: load_c = {{16{~uns_q & shifted_c[15]}}, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
        mask_c  = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt_c;
        merge_c = (bus_r_data & ~mask_c) | ((wdata_q << shamt_c) & mask_c);
    end

    // Control FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            r_en_q     <= 1'b0;
            w_en_q     <= 1'b0;
            bus_r_addr <= 32'h0;
            bus_w_addr <= 32'h0;
            bus_w_data <= 32'h0;
            lat_cnt    <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_WORD;
            lane_q     <= 2'b00;
            wdata_q    <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            r_en_q    <= 1'b0;
            w_en_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        size_q    <= size_c;
                        lane_q    <= lane_c;
                        wdata_q   <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                        fault_q   <= fault_c;
`endif
                        if (fault_c) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else if (req_we && (size_c == SZ_WORD)) begin
                            state      <= WR;
                            w_en_q     <= 1'b1;
                            bus_w_addr <= word_addr_c;
                            bus_w_data <= req_wdata;
                        end else begin
                            state      <= RD;
                            r_en_q     <= 1'b1;
                            bus_r_addr <= word_addr_c;
                        end
                    end
                end
                RD: begin
                    state   <= WAIT;
                    lat_cnt <= LAT_W'(1);
                end
                WAIT: begin
                    if (lat_cnt == LAT_W'(READ_LATENCY)) begin
                        if (we_q) begin
                            state      <= WR;
                            w_en_q     <= 1'b1;
                            bus_w_addr <= bus_r_addr;
                            bus_w_data <= merge_c;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_c;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'h0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Bus enables are masked immediately while reset is asserted
    assign bus_r_en = r_en_q & ~rst;
    assign bus_w_en = w_en_q & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: instance a at READ_LATENCY=1, instance b at 3,
// both backed by one word memory with per-instance read delay lines.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid_a, req_ready_a, req_we_a, req_unsigned_a;
    logic [1:0]  req_size_a;
    logic [31:0] req_addr_a, req_wdata_a;
    logic        rsp_valid_a, rsp_fault_a;
    logic [31:0] rsp_rdata_a;
    logic        bus_r_en_a, bus_w_en_a;
    logic [31:0] bus_r_addr_a, bus_r_data_a, bus_w_addr_a, bus_w_data_a;

    logic        req_valid_b, req_ready_b, req_we_b, req_unsigned_b;
    logic [1:0]  req_size_b;
    logic [31:0] req_addr_b, req_wdata_b;
    logic        rsp_valid_b, rsp_fault_b;
    logic [31:0] rsp_rdata_b;
    logic        bus_r_en_b, bus_w_en_b;
    logic [31:0] bus_r_addr_b, bus_r_data_b, bus_w_addr_b, bus_w_data_b;

    load_store_unit #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_size(req_size_a), .req_unsigned(req_unsigned_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_fault(rsp_fault_a),
        .bus_r_en(bus_r_en_a), .bus_r_addr(bus_r_addr_a), .bus_r_data(bus_r_data_a),
        .bus_w_en(bus_w_en_a), .bus_w_addr(bus_w_addr_a), .bus_w_data(bus_w_data_a)
    );

    load_store_unit #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_size(req_size_b), .req_unsigned(req_unsigned_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_fault(rsp_fault_b),
        .bus_r_en(bus_r_en_b), .bus_r_addr(bus_r_addr_b), .bus_r_data(bus_r_data_b),
        .bus_w_en(bus_w_en_b), .bus_w_addr(bus_w_addr_b), .bus_w_data(bus_w_data_b)
    );

    // Word memory model; poke is a bench-side preload path
    logic [31:0] mem [0:4095];
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr = 32'h0, poke_data = 32'h0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr[13:2]] <= poke_data;
        else if (bus_w_en_a) mem[bus_w_addr_a[13:2]] <= bus_w_data_a;
        if (bus_r_en_a) rd_cnt_a <= rd_cnt_a + 1;
    end

    logic        rv_a = 1'b0;
    logic [31:0] ra_a = 32'h0;
    logic [2:0]  rv_b = 3'b000;
    logic [31:0] ra_b [3];

    always @(posedge clk) begin
        rv_a    <= bus_r_en_a;
        ra_a    <= bus_r_addr_a;
        rv_b    <= {rv_b[1:0], bus_r_en_b};
        ra_b[0] <= bus_r_addr_b;
        ra_b[1] <= ra_b[0];
        ra_b[2] <= ra_b[1];
    end

    assign bus_r_data_a = rv_a    ? mem[ra_a[13:2]]    : 32'hBAD0_BAD0;
    assign bus_r_data_b = rv_b[2] ? mem[ra_b[2][13:2]] : 32'hBAD0_BAD0;

    typedef struct { int cyc; logic [31:0] data; logic fault; } rsp_t;
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;

    rsp_t rq_a[$];
    rsp_t rq_b[$];
    wr_t  wq_a[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expectations whenever the DUTs present a response or a bus write
    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        if (rsp_valid_a) begin
            if (rq_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_a_unexpected: got rsp_valid rdata=0x%08h at cycle %0d expected none", rsp_rdata_a, cyc);
            end else begin
                r = rq_a.pop_front();
                check("rsp_a_cycle", 32'(cyc), 32'(r.cyc));
                check("rsp_a_rdata", rsp_rdata_a, r.data);
                check("rsp_a_fault", 32'(rsp_fault_a), 32'(r.fault));
            end
        end
        if (bus_w_en_a) begin
            if (wq_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_a_unexpected: got write 0x%08h<-0x%08h at cycle %0d expected none", bus_w_addr_a, bus_w_data_a, cyc);
            end else begin
                w = wq_a.pop_front();
                check("wr_a_cycle", 32'(cyc), 32'(w.cyc));
                check("wr_a_addr", bus_w_addr_a, w.addr);
                check("wr_a_data", bus_w_data_a, w.data);
            end
        end
        if (rsp_valid_b) begin
            if (rq_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_b_unexpected: got rsp_valid at cycle %0d expected none", cyc);
            end else begin
                r = rq_b.pop_front();
                check("rsp_b_cycle", 32'(cyc), 32'(r.cyc));
                check("rsp_b_rdata", rsp_rdata_b, r.data);
                check("rsp_b_fault", 32'(rsp_fault_b), 32'(r.fault));
            end
        end
        if (bus_w_en_b) begin
            checks++; errors++;
            $display("FAIL wr_b_unexpected: got write 0x%08h<-0x%08h expected none", bus_w_addr_b, bus_w_data_b);
        end
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Presents one request to instance a; n is the cycle in which it is accepted
    task automatic issue_a(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, output int n);
        int b;
        b = 0;
        @(negedge clk);
        req_valid_a = 1'b1; req_we_a = we; req_size_a = size;
        req_unsigned_a = uns; req_addr_a = addr; req_wdata_a = wdata;
        while (!req_ready_a && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (b >= 100) begin
            checks++; errors++;
            $display("FAIL issue_a_timeout: got req_ready=0 for %0d cycles expected 1", b);
        end
        n = cyc;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0; req_we_a = ~we; req_size_a = ~size;
        req_unsigned_a = ~uns; req_addr_a = 32'hFFFF_FFFF; req_wdata_a = 32'h5A5A_5A5A;
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while ((rq_a.size() != 0 || wq_a.size() != 0 || rq_b.size() != 0) && b < 60) begin
            @(negedge clk);
            b++;
        end
        checks++;
        if (b >= 60) begin
            errors++;
            $display("FAIL %s_drain: got %0d/%0d/%0d pending expected 0", name, rq_a.size(), wq_a.size(), rq_b.size());
        end
    endtask

    task automatic load_a(input logic [31:0] a, input logic [1:0] s, input logic u, input logic [31:0] e);
        int n;
        issue_a(1'b0, s, u, a, 32'h0, n);
        rq_a.push_back('{n + 3, e, 1'b0});
        drain("load");
    endtask

    task automatic store_sub_a(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input logic [31:0] merged);
        int n;
        int r0;
        r0 = rd_cnt_a;
        issue_a(1'b1, s, 1'b0, a, d, n);
        wq_a.push_back('{n + 3, {a[31:2], 2'b00}, merged});
        rq_a.push_back('{n + 4, 32'h0, 1'b0});
        drain("store_sub");
        check("store_sub_reads", 32'(rd_cnt_a - r0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r0;
        rst = 1'b1;
        req_valid_a = 1'b0; req_we_a = 1'b0; req_size_a = 2'b00; req_unsigned_a = 1'b0;
        req_addr_a = 32'h0; req_wdata_a = 32'h0;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_size_b = 2'b00; req_unsigned_b = 1'b0;
        req_addr_b = 32'h0; req_wdata_b = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready_a), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("reset_rsp_rdata", rsp_rdata_a, 32'h0);
        check("reset_rsp_fault", 32'(rsp_fault_a), 32'd0);
        check("reset_bus_r_en", 32'(bus_r_en_a), 32'd0);
        check("reset_bus_w_en", 32'(bus_w_en_a), 32'd0);
        check("reset_bus_r_addr", bus_r_addr_a, 32'h0);
        check("reset_bus_w_addr", bus_w_addr_a, 32'h0);
        check("reset_bus_w_data", bus_w_data_a, 32'h0);
        check("reset_req_ready_b", 32'(req_ready_b), 32'd1);
        rst = 1'b0;

        // Word store then word load
        issue_a(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF, n);
        wq_a.push_back('{n + 1, 32'h1000, 32'hDEAD_BEEF});
        rq_a.push_back('{n + 2, 32'h0, 1'b0});
        drain("word_store");
        load_a(32'h1000, 2'b10, 1'b0, 32'hDEAD_BEEF);

        // Byte store read-modify-write
        poke(32'h1000, 32'h1122_3344);
        store_sub_a(32'h1002, 2'b00, 32'h0000_00AA, 32'h11AA_3344);
        load_a(32'h1000, 2'b10, 1'b0, 32'h11AA_3344);

        // Sub-word load lanes and extension
        poke(32'h1000, 32'h8001_FF7F);
        load_a(32'h1000, 2'b10, 1'b1, 32'h8001_FF7F);
        load_a(32'h1000, 2'b00, 1'b0, 32'h0000_007F);
        load_a(32'h1001, 2'b00, 1'b0, 32'hFFFF_FFFF);
        load_a(32'h1001, 2'b00, 1'b1, 32'h0000_00FF);
        load_a(32'h1003, 2'b00, 1'b0, 32'hFFFF_FF80);
        load_a(32'h1000, 2'b01, 1'b0, 32'hFFFF_FF7F);
        load_a(32'h1002, 2'b01, 1'b1, 32'h0000_8001);
        load_a(32'h1002, 2'b01, 1'b0, 32'hFFFF_8001);
        repeat (3) @(negedge clk);
        check("rdata_hold", rsp_rdata_a, 32'hFFFF_8001);

        // Half store into upper lane ignores upper store-data bits
        store_sub_a(32'h1002, 2'b01, 32'hFFFF_1234, 32'h1234_FF7F);
        load_a(32'h1000, 2'b10, 1'b0, 32'h1234_FF7F);

        // Misaligned half and illegal size
        r0 = rd_cnt_a;
        issue_a(1'b0, 2'b01, 1'b0, 32'h1001, 32'h0, n);
`ifdef LSU_MISALIGN_TRAP_EN
        rq_a.push_back('{n + 1, 32'h0, 1'b1});
        drain("misalign_half");
        check("misalign_half_reads", 32'(rd_cnt_a - r0), 32'd0);
        issue_a(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, n);
        rq_a.push_back('{n + 1, 32'h0, 1'b1});
        drain("illegal_size");
        issue_a(1'b1, 2'b10, 1'b0, 32'h1003, 32'h0BAD_0BAD, n);
        rq_a.push_back('{n + 1, 32'h0, 1'b1});
        drain("misalign_word_store");
        check("misalign_reads_total", 32'(rd_cnt_a - r0), 32'd0);
`else
        rq_a.push_back('{n + 3, 32'hFFFF_FF7F, 1'b0});
        drain("misalign_half");
        check("misalign_half_reads", 32'(rd_cnt_a - r0), 32'd1);
        issue_a(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, n);
        rq_a.push_back('{n + 3, 32'h1234_FF7F, 1'b0});
        drain("illegal_size");
`endif

        // Reset in the middle of a half store drops the write
        poke(32'h1000, 32'h1122_3344);
        r0 = rd_cnt_a;
        issue_a(1'b1, 2'b01, 1'b0, 32'h1000, 32'h0000_BEEF, n);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_req_ready", 32'(req_ready_a), 32'd1);
        check("abort_mem", mem[12'h400], 32'h1122_3344);
        check("abort_reads", 32'(rd_cnt_a - r0), 32'd1);
        load_a(32'h1000, 2'b10, 1'b0, 32'h1122_3344);

        // READ_LATENCY=3 with req_valid held through the busy period
        poke(32'h2000, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid_b = 1'b1; req_we_b = 1'b0; req_size_b = 2'b10;
        req_unsigned_b = 1'b0; req_addr_b = 32'h2000; req_wdata_b = 32'h0;
        check("b_ready_idle", 32'(req_ready_b), 32'd1);
        n = cyc;
        @(posedge clk);
        #1;
        req_size_b = 2'b00; req_unsigned_b = 1'b1; req_addr_b = 32'h2003;
        rq_b.push_back('{n + 5, 32'hCAFE_F00D, 1'b0});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("b_ready_busy", 32'(req_ready_b), 32'd0);
        end
        @(negedge clk);
        check("b_ready_again", 32'(req_ready_b), 32'd1);
        check("b_accept_cycle", 32'(cyc), 32'(n + 6));
        rq_b.push_back('{n + 11, 32'h0000_00CA, 1'b0});
        @(posedge clk);
        #1 req_valid_b = 1'b0;
        drain("latency3");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and data_bus.
- Converts byte, halfword and word load/store requests into word-only bus transactions.
- Sub-word loads: extracts the addressed lane and sign/zero-extends it.
- Sub-word stores: read-modify-write, because data_bus carries no byte strobes. One request in flight at a time.

Parameters:
READ_LATENCY, 1, cycles from bus_r_en to valid bus_r_data (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, can accept request
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data (0 for stores/faults)
rsp_fault  out  1  misaligned/illegal access (with macro only)
bus_r_en  out  1  to data_bus r_en
bus_r_addr  out  32  to data_bus r_addr, word-aligned
bus_r_data  in  32  from data_bus r_data
bus_w_en  out  1  to data_bus w_en
bus_w_addr  out  32  to data_bus w_addr, word-aligned
bus_w_data  out  32  to data_bus w_data

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, bus_*_en=0, bus addrs/data=0.
- Gating: bus_r_en and bus_w_en are combinationally forced 0 while rst=1.
- States: IDLE, RD, WAIT, WR, RESP.
- Acceptance: on the edge where req_valid & req_ready. req_ready=1 only in IDLE. Request fields are latched at acceptance; later changes on req_* are ignored.
- Bus addressing: word = {addr[31:2],2'b00}. Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
- RD: bus_r_en=1 for exactly one cycle, then WAIT. Its one-hot timing is shown in the latency table below.
- WAIT: latency counter (4 bits) runs READ_LATENCY cycles. bus_r_addr is held stable from RD until bus_r_data is sampled, in the cycle READ_LATENCY after bus_r_en.
- Load completion:
  - Shift right by 8*lane.
  - Byte: extend bit 7. Half: extend bit 15 (or zero-extend if req_unsigned).
  - Word: pass through, req_unsigned ignored.
  - Then go to RESP.
- Word store: skips RD/WAIT. WR drives bus_w_en=1 for one cycle with bus_w_data=req_wdata.
- Sub-word store: RD/WAIT as for a load. The sampled word is merged with req_wdata[7:0] or [15:0] at the lane; all other lanes are preserved. Then WR writes the merged word.
- RESP: rsp_valid=1 for one cycle, then IDLE. There is no response backpressure. rsp_rdata holds its value until the next RESP.
- Latency in cycles after the acceptance edge N (L=READ_LATENCY), relative to the cycle numbers below:
  - Word store: bus_w_en at N+1, rsp_valid at N+2.
  - Load: bus_r_en at N+1, data sampled at N+1+L, rsp_valid at N+2+L.
  - Sub-word store: bus_r_en at N+1, bus_w_en at N+2+L, rsp_valid at N+3+L.
- Back-to-back: the next request is accepted in the cycle after RESP. Minimum spacing is 3 cycles.
- Reset mid-operation: returns to IDLE next edge. Any pending RMW write is dropped and memory is left unchanged. No rsp_valid for the aborted request.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - Half with addr[0]=1, word with addr[1:0]!=0, or req_size=11 is a fault.
  - Accepted normally, then no bus traffic.
  - rsp_valid at N+1 with rsp_fault=1, rsp_rdata=0.
- Undefined:
  - rsp_fault is tied 0.
  - Misaligned low address bits are truncated (half uses addr[1], word ignores addr[1:0]).
  - req_size=11 is treated as word.

Test Plan:
- Word store 0x1000<-0xDEADBEEF (accept N), then word load 0x1000 -> bus_w_en at N+1; load rsp_rdata=0xDEADBEEF, 3 cycles after its accept (L=1).
- Memory 0x1000=0x11223344; byte store 0x1002<-0x000000AA -> one bus_r_en, bus_w_data=0x11AA3344, rsp_valid at N+4; word readback 0x11AA3344.
- Memory 0x1000=0x8001FF7F: signed byte 0x1000 -> 0x0000007F; signed byte 0x1001 -> 0xFFFFFFFF; unsigned half 0x1002 -> 0x00008001; signed half 0x1002 -> 0xFFFF8001.
- Half load 0x1001: with macro -> rsp_fault=1 at N+1, no bus_r_en/bus_w_en; without -> reads 0x1000 lane 0, rsp_fault=0.
- rst pulsed at N+2 during halfword store to 0x1000 -> no bus_w_en, memory unchanged, no rsp_valid, req_ready=1 after reset.
- req_valid held during busy load with READ_LATENCY=3 -> req_ready=0 until rsp_valid at N+5; second request accepted at N+6.
